// File: rtl/transmit_if.sv
// Byte handshake between the parallel producer and the serial transmitter.
interface transmit_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/transmit.sv
// Serial frame transmitter: FIFO-buffered bytes sent as start 0, D7..D0, end 0, idle high.
// Optional frame counter output tx_count enabled by defining TX_FRAME_COUNT_EN.
module transmit #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    transmit_if.slave  bus,
    output logic       txd,
    output logic       busy
`ifdef TX_FRAME_COUNT_EN
    ,
    output logic [7:0] tx_count
`endif
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW    = AW + 1;
    localparam int unsigned CYC_MAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
    localparam int unsigned CW      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_END, S_GAP} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_next;
    logic            ready_q;
    logic [CW-1:0]   cyc;
    logic [2:0]      bit_idx;
    logic [7:0]      sh;
    logic            push;
    logic            pop;
    logic            bit_last;
    logic            gap_last;
    logic            idle_next;

    assign bus.data_ready = ready_q;

    // Handshake, pop decision and next occupancy
    always_comb begin
        push       = bus.data_valid && ready_q;
        bit_last   = (cyc == CW'(BIT_CYCLES - 1));
        gap_last   = (cyc == CW'(GAP_CYCLES - 1));
        pop        = (count != '0) && ((state == S_IDLE) || ((state == S_GAP) && gap_last));
        idle_next  = !pop && ((state == S_IDLE) || ((state == S_GAP) && gap_last));
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNTW'(1);
            2'b01:   count_next = count - CNTW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage is not reset; pointers and occupancy define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_q  <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
            txd      <= 1'b1;
            cyc      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
`ifdef TX_FRAME_COUNT_EN
            tx_count <= '0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_next;
            ready_q <= (count_next != CNTW'(DEPTH));
            busy    <= (count_next != '0) || !idle_next;

            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        sh    <= mem[rd_ptr];
                        cyc   <= '0;
                        txd   <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bit_last) begin
                        cyc     <= '0;
                        bit_idx <= '0;
                        txd     <= sh[7];
                        state   <= S_DATA;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_last) begin
                        cyc <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b0;
                            state <= S_END;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            sh      <= {sh[6:0], 1'b0};
                            txd     <= sh[6];
                        end
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                S_END: begin
                    if (bit_last) begin
                        cyc   <= '0;
                        txd   <= 1'b1;
                        state <= S_GAP;
`ifdef TX_FRAME_COUNT_EN
                        tx_count <= tx_count + 8'd1;
`endif
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_last) begin
                        cyc <= '0;
                        // Back-to-back: next start bit follows the last gap clock directly
                        if (pop) begin
                            sh    <= mem[rd_ptr];
                            txd   <= 1'b0;
                            state <= S_START;
                        end else begin
                            txd   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    cyc   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmit.sv
// Randomized and directed bench for transmit; two instances (default timing and
// BIT_CYCLES=3/GAP_CYCLES=2) share stimulus and are checked against a frame-position model.
module tb_transmit;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    transmit_if bus0 ();
    transmit_if bus1 ();
    logic txd0, txd1, busy0, busy1;
`ifdef TX_FRAME_COUNT_EN
    logic [7:0] tc0, tc1;
`endif

    transmit #(.DEPTH(DEPTH), .BIT_CYCLES(1), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .txd(txd0), .busy(busy0)
`ifdef TX_FRAME_COUNT_EN
        , .tx_count(tc0)
`endif
    );

    transmit #(.DEPTH(DEPTH), .BIT_CYCLES(3), .GAP_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .txd(txd1), .busy(busy1)
`ifdef TX_FRAME_COUNT_EN
        , .tx_count(tc1)
`endif
    );

    // Reference model: queue of accepted bytes plus position inside the current frame
    int         pos    [2];
    logic [7:0] cur    [2];
    logic [7:0] qb     [2][64];
    int         qh     [2];
    int         qn     [2];
    logic       mready [2];
    logic [7:0] mcount [2];
    int         pushes [2];
    logic       pushed [2];

    int compared   = 0;
    int mismatched = 0;

    function automatic int bc_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int gc_of(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic exp_txd(int i);
        int idx;
        if (pos[i] < 0) return 1'b1;
        idx = pos[i] / bc_of(i);
        if (idx == 0 || idx == 9) return 1'b0;
        if (idx >= 10) return 1'b1;
        return cur[i][8 - idx];
    endfunction

    function automatic logic exp_busy(int i);
        return (qn[i] > 0) || (pos[i] >= 0);
    endfunction

    task automatic model_edge(input int i, input logic r, input logic v, input logic [7:0] d);
        int   per;
        logic do_push;
        per       = 10 * bc_of(i) + gc_of(i);
        pushed[i] = 1'b0;
        if (r) begin
            pos[i]    = -1;
            qh[i]     = 0;
            qn[i]     = 0;
            mready[i] = 1'b1;
            mcount[i] = 8'd0;
        end else begin
            do_push = v && mready[i];
            if (pos[i] >= 0) begin
                if (pos[i] == 10 * bc_of(i) - 1) mcount[i] = mcount[i] + 8'd1;
                pos[i] = pos[i] + 1;
                if (pos[i] == per) pos[i] = -1;
            end
            if (pos[i] < 0 && qn[i] > 0) begin
                cur[i] = qb[i][qh[i]];
                qh[i]  = (qh[i] + 1) % 64;
                qn[i]  = qn[i] - 1;
                pos[i] = 0;
            end
            if (do_push) begin
                qb[i][(qh[i] + qn[i]) % 64] = d;
                qn[i]     = qn[i] + 1;
                pushes[i] = pushes[i] + 1;
                pushed[i] = 1'b1;
            end
            mready[i] = (qn[i] < DEPTH);
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        rst             = r;
        bus0.data_valid = v;
        bus1.data_valid = v;
        bus0.data_in    = d;
        bus1.data_in    = d;
        @(posedge clk);
        model_edge(0, r, v, d);
        model_edge(1, r, v, d);
        #1;
        check("txd0",   {7'd0, txd0},            {7'd0, exp_txd(0)});
        check("busy0",  {7'd0, busy0},           {7'd0, exp_busy(0)});
        check("ready0", {7'd0, bus0.data_ready}, {7'd0, mready[0]});
        check("txd1",   {7'd0, txd1},            {7'd0, exp_txd(1)});
        check("busy1",  {7'd0, busy1},           {7'd0, exp_busy(1)});
        check("ready1", {7'd0, bus1.data_ready}, {7'd0, mready[1]});
`ifdef TX_FRAME_COUNT_EN
        check("tx_count0", tc0, mcount[0]);
        check("tx_count1", tc1, mcount[1]);
`endif
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && (exp_busy(0) || exp_busy(1)); n++) step(1'b0, 1'b0, 8'h00);
        check("drain_idle", {7'd0, exp_busy(0) || exp_busy(1)}, 8'd0);
    endtask

    initial begin
        int         acc;
        logic       dropped;
        logic       prev_ready;
        logic [7:0] data;
        int         p0;

        for (int i = 0; i < 2; i++) begin
            pos[i] = -1; qh[i] = 0; qn[i] = 0; mready[i] = 1'b1;
            mcount[i] = 8'd0; pushes[i] = 0; pushed[i] = 1'b0; cur[i] = 8'h00;
        end

        // Reset state
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hEE);
        check("reset_txd",   {7'd0, txd0},            8'd1);
        check("reset_busy",  {7'd0, busy0},           8'd0);
        check("reset_ready", {7'd0, bus0.data_ready}, 8'd1);

        // Single 0xA5 frame; also 0x81 on the slow instance later
        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b0, 8'h00);
        check("a5_start_bit", {7'd0, txd0}, 8'd0);
        drain();

        // Producer holds valid: five bytes accepted before the FIFO fills
        acc = 0; dropped = 1'b0; prev_ready = bus0.data_ready; data = 8'h10;
        for (int n = 0; n < 60; n++) begin
            step(1'b0, 1'b1, data);
            if (!dropped && prev_ready) acc++;
            if (!bus0.data_ready) dropped = 1'b1;
            prev_ready = bus0.data_ready;
            if (pushed[0]) data = data + 8'd1;
        end
        check("accepted_before_full", 8'(acc), 8'd5);
        drain();

        // 0x00 and 0xFF back-to-back
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        drain();

        step(1'b0, 1'b1, 8'h81);
        drain();

        // Reset during DATA of the second of three queued bytes
        step(1'b0, 1'b1, 8'h31);
        step(1'b0, 1'b1, 8'h32);
        step(1'b0, 1'b1, 8'h33);
        for (int n = 0; n < 12; n++) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("midrst_txd",   {7'd0, txd0},            8'd1);
        check("midrst_busy",  {7'd0, busy0},           8'd0);
        check("midrst_ready", {7'd0, bus0.data_ready}, 8'd1);
        for (int n = 0; n < 30; n++) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3C);
        drain();

        // Random traffic with occasional resets
        for (int n = 0; n < 1200; n++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
        end
        drain();

`ifdef TX_FRAME_COUNT_EN
        // 257 frames wrap the counter to 1; an aborted frame is not counted
        step(1'b1, 1'b0, 8'h00);
        p0 = pushes[0];
        for (int n = 0; n < 4000 && (pushes[0] - p0) < 257; n++) begin
            step(1'b0, ((pushes[0] - p0) < 257), 8'($urandom));
        end
        check("pushed_257", 8'(pushes[0] - p0), 8'(257));
        drain();
        check("tx_count_257", tc0, 8'd1);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h55);
        for (int n = 0; n < 6; n++) step(1'b0, 1'b0, 8'h00);
        check("abort_no_count", tc0, 8'd0);
        step(1'b1, 1'b0, 8'h00);
        check("abort_count_rst", tc0, 8'd0);
        step(1'b0, 1'b1, 8'h3C);
        drain();
        check("count_after_abort", tc0, 8'd1);
`else
        p0 = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/transmit.md
Name: transmit

Overview:
- Serial frame transmitter; drives the serial line into the existing receive stage, directly upstream of it.
- Accepts bytes from a parallel producer through a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte into the one-wire frame the receive stage decodes: start 0, D7..D0 MSB first, end 0, then idle high.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- BIT_CYCLES, 1, clocks per serial bit; 1 matches the receive stage (one bit per clock).
- GAP_CYCLES, 1, idle-high clocks after each frame's end bit; minimum 1. The receive stage needs at least 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  byte to send.
- data_valid  input  1  producer presents data_in.
- data_ready  output  1  FIFO can accept; a transfer occurs on an edge with data_valid && data_ready.
- txd  output  1  serial line, registered, idle high.
- busy  output  1  high while the FIFO is non-empty or the FSM is not IDLE.

Behaviour:
- Reset (rst high at an edge): txd=1, busy=0, data_ready=1, FIFO empty, FSM=IDLE, bit and gap counters 0. rst overrides all other inputs.
- Reset mid-frame: the frame is truncated, txd returns to 1 on the next edge, and queued bytes are discarded. The system resets the receive stage at the same time.
- FIFO:
  - data_ready = !full, derived from registered occupancy.
  - Push and pop on the same edge is allowed when not full; occupancy is unchanged.
  - No push when full. data_valid while data_ready is low is ignored, and the producer holds data_in.
  - Pointers wrap modulo DEPTH. Occupancy counter width is log2(DEPTH)+1.
- FSM states: IDLE, START, DATA, END, GAP.
  - IDLE: txd=1. If the FIFO is non-empty, pop into shift register sh[7:0], load the bit counter, and go to START. txd=0 is visible after that same edge.
  - START: txd=0 for BIT_CYCLES clocks, then DATA with txd=sh[7].
  - DATA: each bit is held for BIT_CYCLES clocks, then sh shifts left. Eight bits are sent MSB first; after D0, go to END.
  - END: txd=0 for BIT_CYCLES clocks, then GAP.
  - GAP: txd=1 for GAP_CYCLES clocks. On the last gap clock, if the FIFO is non-empty, pop and go directly to START (back-to-back); otherwise go to IDLE.
- Latency: a byte accepted at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1. The start bit drives txd from edge k+1.
- Frame period: 10*BIT_CYCLES + GAP_CYCLES clocks; 11 with defaults.
- busy falls the edge the FSM enters IDLE with the FIFO empty.
- The shift register is loaded only at pop. data_in changes during a frame have no effect on it.

Optional Feature:
- Macro TX_FRAME_COUNT_EN.
- Defined:
  - Adds output port tx_count[7:0], reset 0.
  - Increments by 1 on the edge leaving END, wraps 255 to 0.
  - Increments only for frames that complete their end bit; frames truncated by rst are not counted.
- Undefined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Single byte 0xA5, defaults, idle FSM: accepted at edge k; txd from edge k+1 is 0,1,0,1,0,0,1,0,1,0, then 1. A connected receive stage outputs word=0xA5 and recieve_ready=1. busy falls after the gap.
- Hold data_valid high with data 0x10,0x11,... every accepted edge, defaults: exactly 5 bytes (0x10..0x14) are accepted before data_ready drops. data_ready stays low with occupancy 4 until the next pop at the GAP-to-START edge, where it rises. Frames emerge in order every 11 clocks with txd low at each frame start.
- Bytes 0x00 and 0xFF back-to-back: the 0x00 frame is 10 consecutive zeros then a single 1. The 0xFF frame starts the next clock, and the receive stage decodes both.
- BIT_CYCLES=3, GAP_CYCLES=2, byte 0x81: each bit is held 3 clocks; frame 32 clocks; txd pattern 000 111 000x6 111 000 11.
- rst pulsed during DATA of the second of 3 queued bytes: txd=1, busy=0, data_ready=1 after the edge. No further frames are sent, and a new push of 0x3C transmits correctly.
- TX_FRAME_COUNT_EN defined: send 257 frames and check tx_count=1. A frame aborted by rst does not increment.
